// File: rtl/aes128_encrypt_iter_if.sv
// Handshake bundle for aes128_encrypt_iter: plaintext/key request side and ciphertext response side.
interface aes128_encrypt_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;

   modport master (
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext, busy
   );

   modport slave (
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext, busy
   );
endinterface

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core; UNROLL rounds per clock, round keys expanded on the fly.
// Byte 0 of every 128-bit block sits in bits [127:120].
module aes128_encrypt_iter #(
   parameter int NR     = 10,
   parameter int UNROLL = 1
) (
   input logic               clk,
   input logic               rst_n,
   aes128_encrypt_iter_if.slave bus
);

   if (NR != 10) begin : g_nr_check
      $error("aes128_encrypt_iter: NR must be 10");
   end
   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_unroll_check
      $error("aes128_encrypt_iter: UNROLL must be 1, 2, 5 or 10");
   end

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int unsigned UNR  = UNROLL;
   localparam logic [3:0]  STEP = 4'(UNROLL);
   localparam logic [3:0]  LAST = 4'(NR);

   typedef logic [0:15][7:0] blk_t;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return SBOX[idx +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rn);
      case (rn)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic blk_t sub_bytes(input blk_t s);
      blk_t o;
      for (int unsigned i = 0; i < 16; i++) o[i] = sbox(s[i]);
      return o;
   endfunction

   // Column-major state: byte 4*c+r is row r of column c; row r rotates left by r.
   function automatic blk_t shift_rows(input blk_t s);
      return {s[0],  s[5],  s[10], s[15], s[4],  s[9],  s[14], s[3],
              s[8],  s[13], s[2],  s[7],  s[12], s[1],  s[6],  s[11]};
   endfunction

   function automatic blk_t mix_columns(input blk_t s);
      blk_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[4*c];
         a1 = s[4*c+1];
         a2 = s[4*c+2];
         a3 = s[4*c+3];
         o[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] key_gen(input logic [127:0] k, input logic [3:0] rn);
      logic [31:0] t, n0, n1, n2, n3;
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(rn), 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64]  ^ n0;
      n2 = k[63:32]  ^ n1;
      n3 = k[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   logic [1:0]   fsm;
   logic [127:0] state_q;
   logic [127:0] rkey_q;
   logic [127:0] ct_q;
   logic [3:0]   rc;
   logic [3:0]   round_cnt;
   logic         out_valid_q;
   logic [127:0] state_nx;
   logic [127:0] rkey_nx;
   logic         in_ready;
   logic         accept;
   logic         last_step;

   assign in_ready  = rst_n & ((fsm == IDLE) | ((fsm == DONE) & bus.out_ready));
   assign accept    = bus.in_valid & in_ready;
   assign last_step = (round_cnt + STEP) == LAST;

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.ciphertext = ct_q;
   assign bus.busy       = (fsm == RUN);

   always_comb begin
      blk_t       s;
      logic [127:0] k;
      logic [3:0] rn;
      s  = state_q;
      k  = rkey_q;
      rn = '0;
      for (int unsigned u = 0; u < UNR; u++) begin
         rn = rc + 4'(u);
         k  = key_gen(k, rn);
         s  = shift_rows(sub_bytes(s));
         if (rn != LAST) s = mix_columns(s);
         s  = s ^ k;
      end
      state_nx = s;
      rkey_nx  = k;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= IDLE;
         state_q     <= '0;
         rkey_q      <= '0;
         ct_q        <= '0;
         rc          <= '0;
         round_cnt   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            state_q   <= bus.plaintext ^ bus.key;
            rkey_q    <= bus.key;
            rc        <= 4'd1;
            round_cnt <= '0;
         end
         case (fsm)
            IDLE: if (accept) fsm <= RUN;
            RUN: begin
               state_q   <= state_nx;
               rkey_q    <= rkey_nx;
               round_cnt <= round_cnt + STEP;
               if (last_step) begin
                  ct_q        <= state_nx;
                  out_valid_q <= 1'b1;
                  rc          <= LAST;
                  fsm         <= DONE;
               end else begin
                  rc <= rc + STEP;
               end
            end
            DONE: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               fsm         <= accept ? RUN : IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
